// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the CPU MEM stage and a debug access port.
// The CPU owns the port by default; a debug request is served for one cycle,
// either when the CPU is idle or after a bounded starvation wait.
//
// state   | meaning
// --------+--------------------------------------------------------------
// CPU_OWN | memory port mirrors cpu_*, starve counter tracks blocked debug
// DBG_OWN | memory port driven by debug request, CPU stalled if accessing

module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cpu_rd,
    input  logic                  cpu_wr,
    input  logic [DM_ADDRESS-1:0] cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    input  logic [2:0]            cpu_funct3,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  cpu_stall,

    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    output logic                  dbg_gnt,
    output logic                  dbg_valid,
    output logic [DATA_W-1:0]     dbg_rdata,

    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rdata
);

    typedef enum logic {
        CPU_OWN = 1'b0,
        DBG_OWN = 1'b1
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                dbg_valid_q, dbg_valid_d;
    logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
    logic                cpu_access;

    assign cpu_access = cpu_rd | cpu_wr;
    assign cpu_rdata  = mem_rdata;
    assign dbg_valid  = dbg_valid_q;
    assign dbg_rdata  = dbg_rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= CPU_OWN;
            cnt_q       <= 4'd0;
            dbg_valid_q <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dbg_valid_q <= dbg_valid_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Memory port mux; the state register resets asynchronously so the CPU
    // path is restored the instant reset asserts.
    always_comb begin
        mem_rd     = cpu_rd;
        mem_wr     = cpu_wr;
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        mem_funct3 = cpu_funct3;
        cpu_stall  = 1'b0;
        dbg_gnt    = 1'b0;
        if (state_q == DBG_OWN) begin
            mem_rd     = dbg_req & ~dbg_we;
            mem_wr     = dbg_req & dbg_we;
            mem_addr   = dbg_addr;
            mem_wdata  = dbg_wdata;
            mem_funct3 = 3'b010;
            cpu_stall  = cpu_access;
            dbg_gnt    = dbg_req;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dbg_valid_d = 1'b0;
        dbg_rdata_d = dbg_rdata_q;
        case (state_q)
            CPU_OWN: begin
                if (dbg_req && (!cpu_access || cnt_q == STARVE_LIM)) begin
                    state_d = DBG_OWN;
                    cnt_d   = 4'd0;
                end else if (dbg_req && cpu_access && cnt_q != STARVE_LIM) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DBG_OWN: begin
                state_d     = CPU_OWN;
                dbg_valid_d = dbg_req;
                if (dbg_req && !dbg_we) begin
                    dbg_rdata_d = mem_rdata;
                end
            end
            default: state_d = CPU_OWN;
        endcase
    end

endmodule
